// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit multiplexed display scanner. A load is held in a pending buffer
// and committed only at a frame boundary, so that no frame shows a mix of old and new data.
module disp_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  le_in,
    input  logic        lz_blank,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  AN,
    output logic [3:0]  hex,
    output logic        LE,
    output logic        point,
    output logic        frame_done
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [7:0]    act_pt_q, act_pt_d, act_le_q, act_le_d;
    logic [7:0]    pend_pt_q, pend_pt_d, pend_le_q, pend_le_d;
    logic          pend_v_q, pend_v_d;
    logic [7:0]    an_q, an_d;
    logic [3:0]    hex_q, hex_d;
    logic          le_q, le_d, pt_q, pt_d, fd_q, ack_q;
    logic          tick, bnd, commit, lz_hit;

    always_comb begin
        tick        = presc_q == PW'(SCAN_DIV - 1);
        bnd         = tick && idx_q == 3'd7;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        // A load landing on the boundary goes straight to the active set and wins over any pending one
        commit      = bnd && (load || pend_v_q);
        act_data_d  = !commit ? act_data_q : load ? data_in  : pend_data_q;
        act_pt_d    = !commit ? act_pt_q   : load ? point_in : pend_pt_q;
        act_le_d    = !commit ? act_le_q   : load ? le_in    : pend_le_q;
        pend_data_d = load ? data_in  : pend_data_q;
        pend_pt_d   = load ? point_in : pend_pt_q;
        pend_le_d   = load ? le_in    : pend_le_q;
        pend_v_d    = bnd ? 1'b0 : (load || pend_v_q);
        lz_hit      = lz_blank && idx_q != 3'd0 && (act_data_q >> {idx_q, 2'b00}) == 32'd0;
        an_d        = ~(8'd1 << idx_q);
        hex_d       = act_data_q[{idx_q, 2'b00} +: 4];
        le_d        = act_le_q[idx_q] || lz_hit;
        pt_d        = act_pt_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            act_data_q  <= '0;
            act_pt_q    <= '0;
            act_le_q    <= '0;
            pend_data_q <= '0;
            pend_pt_q   <= '0;
            pend_le_q   <= '0;
            pend_v_q    <= 1'b0;
            an_q        <= 8'hFF;
            hex_q       <= '0;
            le_q        <= 1'b1;
            pt_q        <= 1'b0;
            fd_q        <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_pt_q    <= act_pt_d;
            act_le_q    <= act_le_d;
            pend_data_q <= pend_data_d;
            pend_pt_q   <= pend_pt_d;
            pend_le_q   <= pend_le_d;
            pend_v_q    <= pend_v_d;
            an_q        <= an_d;
            hex_q       <= hex_d;
            le_q        <= le_d;
            pt_q        <= pt_d;
            fd_q        <= bnd;
            ack_q       <= commit;
        end
    end

    assign AN         = an_q;
    assign hex        = hex_q;
    assign LE         = le_q;
    assign point      = pt_q;
    assign frame_done = fd_q;
    assign load_ack   = ack_q;
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles each digit is held; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 data_in  input  32  hex value to display; nibble i drives digit i, digit 0 rightmost.
REQ-005 point_in  input  8  decimal-point enables, bit i = digit i, 1 = lit.
REQ-006 le_in  input  8  per-digit blank mask, bit i = 1 blanks digit i.
REQ-007 lz_blank  input  1  1 = suppress leading zeros; sampled live, not buffered.
REQ-008 load  input  1  one-cycle strobe; captures data_in/point_in/le_in into the pending buffer.
REQ-009 load_ack  output  1  one-cycle pulse when a pending buffer becomes the active display.
REQ-010 AN  output  8  digit anode selects, active-low, exactly one low outside reset.
REQ-011 hex  output  4  nibble for the selected digit, to the 7-segment decoder's D3..D0.
REQ-012 LE  output  1  blank for the selected digit, to the decoder's LE; 1 = all segments off.
REQ-013 point  output  1  decimal-point enable for the selected digit, to the decoder's point.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each 8-digit scan.

Function
REQ-015 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; tick is asserted in the cycle the count equals SCAN_DIV-1.
REQ-016 Digit index (3 bits) increments on tick and wraps 7 -> 0.
REQ-017 Frame boundary is the cycle where tick=1 and index=7; frame_done=1 in the following cycle only.
REQ-018 load=1 writes data_in, point_in and le_in into pending registers and sets pending_valid; a later load before commit overwrites them, last one wins.
REQ-019 At a frame boundary with pending_valid=1:
- pending is copied to the active registers;
- pending_valid is cleared;
- load_ack=1 in the following cycle.
REQ-020 At a frame boundary with pending_valid=0, the active registers hold and load_ack stays 0.
REQ-021 load=1 in a frame-boundary cycle writes data_in, point_in and le_in directly to the active registers, clears pending_valid and produces load_ack; one ack only.
REQ-022 The display never shows a mix of old and new buffers within one frame.
REQ-023 All outputs are registered, with one cycle of latency from the index/active state.
- AN = bitwise NOT of (1 << index).
- hex = active nibble[index].
- point = active point[index].
REQ-024 LE = active le[index] OR lz_hit.
- lz_hit = lz_blank AND index >= 1 AND active nibbles 7 down to index are all zero.
- Digit 0 is never blanked by zero suppression.
REQ-025 An active value of 0x00000000 with lz_blank=1 displays a single "0" on digit 0.
REQ-026 hex is driven with the true nibble even when LE=1.

Reset
REQ-027 While rst=1:
- prescaler = 0; index = 0;
- active and pending registers = 0; pending_valid = 0;
- AN = 8'hFF; hex = 0; LE = 1; point = 0;
- frame_done = 0; load_ack = 0.
REQ-028 In the first cycle after rst falls, AN = 8'hFE with digit 0 content.
REQ-029 rst asserted mid-frame or with a load pending discards the pending load; no load_ack is issued.
REQ-030 rst has priority over load and tick in the same cycle.

Verification (SCAN_DIV=4)
REQ-031 Reset, then run 40 cycles. Required response:
- AN walks FE, FD, FB, F7, EF, DF, BF, 7F, each value held for 4 cycles, then repeats;
- frame_done pulses once every 32 cycles.
REQ-032 load with data_in=0x12345678, point_in=0x01, le_in=0x00 mid-frame. Required response:
- old content persists until the boundary;
- load_ack pulses once at the boundary;
- the next frame shows hex 8, 7, 6, 5, 4, 3, 2, 1 for digits 0..7;
- point=1 only on digit 0.
REQ-033 Two loads in one frame, 0x11111111 then 0x22222222. Required response: a single load_ack, and only 0x22222222 is displayed.
REQ-034 load with 0x000000A0 and lz_blank=1. Required response:
- LE=1 on digits 7..2;
- LE=0 on digit 1 (hex A) and digit 0 (hex 0).
- Repeat with 0x00000000: only digit 0 is unblanked.
REQ-035 load coincident with the boundary cycle. Required response: the new data appears on digit 0 in the next frame, with load_ack in the following cycle.
REQ-036 rst pulse with a load pending. Required response: AN=FF during reset, no load_ack, and all digits show hex 0 after reset.
